// File: rtl/seq_min_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_min_pkg
//  Purpose  : Shared types and default sizing for the sequential minimum
//             finder (FSM state encoding, default operand width and count).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_min_pkg;

  // Default operand width and operands per set
  localparam int SEQ_MIN_W = 3;
  localparam int SEQ_MIN_N = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_min_pkg
`default_nettype wire

// File: rtl/seq_min_finder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_min_finder_if
//  Purpose  : Operand / result bundle of the sequential minimum finder.
//  Ports    : none; signals
//               in_data   [W-1:0]     operand value
//               in_strobe             raw slide-switch strobe
//               min_val   [W-1:0]     minimum of the last completed set
//               min_idx   [IDXW-1:0]  lowest index holding min_val
//               valid                 result valid
//               busy                  scan in progress
//               load_cnt  [IDXW:0]    operands captured in current set
//             modport master : stimulus side (drives in_data/in_strobe)
//             modport slave  : finder side
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_min_finder_if
  import seq_min_pkg::*;
#(
  parameter int W = SEQ_MIN_W,
  parameter int N = SEQ_MIN_N
);
  localparam int IDXW = $clog2(N);

  logic [W-1:0]    in_data;
  logic            in_strobe;
  logic [W-1:0]    min_val;
  logic [IDXW-1:0] min_idx;
  logic            valid;
  logic            busy;
  logic [IDXW:0]   load_cnt;

  modport master (
    output in_data, in_strobe,
    input  min_val, min_idx, valid, busy, load_cnt
  );

  modport slave (
    input  in_data, in_strobe,
    output min_val, min_idx, valid, busy, load_cnt
  );

endinterface : seq_min_finder_if
`default_nettype wire

// File: rtl/seq_min_finder_strobe_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_sync_edge
//  Purpose  : Brings a raw asynchronous switch strobe into the clk domain
//             through a 2-flop synchroniser, then a history flop produces a
//             one-cycle rising-edge pulse. All flops reset to 1 so a strobe
//             held high through reset yields no edge.
//  Ports    : clk     in  system clock
//             rst     in  synchronous active-high reset
//             i_async in  raw strobe
//             o_edge  out one-cycle pulse per synchronised rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module strobe_sync_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule : strobe_sync_edge
`default_nettype wire

// File: rtl/seq_min_finder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_min_finder
//  Purpose  : Captures N operands of W bits (one per strobe rising edge) into
//             a register buffer, then scans the buffer one entry per cycle
//             and reports the minimum value and the lowest index holding it.
//             Build macro SEQ_MIN_SIGNED_EN: when defined, operands are
//             compared as two's-complement; otherwise unsigned.
//  Ports    : clk  in  system clock
//             rst  in  synchronous active-high reset
//             bus  seq_min_finder_if.slave (operand in, result out)
//  Params   : W (operand width), N (operands per set, must be >= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_min_finder
  import seq_min_pkg::*;
#(
  parameter int W = SEQ_MIN_W,
  parameter int N = SEQ_MIN_N
) (
  input  wire logic       clk,
  input  wire logic       rst,
  seq_min_finder_if.slave bus
);

  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] C_LAST_P   = IDXW'(N - 1);
  localparam logic [IDXW:0]   C_LAST_CNT = (IDXW + 1)'(N - 1);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_buf [N];
  logic [IDXW:0]   r_load_cnt;
  logic [IDXW-1:0] r_p;
  logic [W-1:0]    r_run_val;
  logic [IDXW-1:0] r_run_idx;
  logic [W-1:0]    r_min_val;
  logic [IDXW-1:0] r_min_idx;

  logic            w_edge;
  logic            w_wr_en;
  logic [IDXW-1:0] w_wr_addr;
  logic [IDXW:0]   w_cnt_nxt;
  logic            w_busy;
  logic            w_valid;
  logic            w_scan_last;
  logic [W-1:0]    w_cur;
  logic            w_less;
  logic            w_take;

  // --------------------------------------------------------------------------
  // Strobe synchronisation and edge detection
  // --------------------------------------------------------------------------
  strobe_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.in_strobe),
    .o_edge  (w_edge)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  assign w_scan_last = (r_p == C_LAST_P);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_load_cnt[IDXW-1:0];
    w_cnt_nxt   = r_load_cnt + 1'b1;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_edge) begin
          w_wr_en = 1'b1;
          if (r_load_cnt == C_LAST_CNT) begin
            w_state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        // Edges seen here are dropped: no write, no count.
        w_busy = 1'b1;
        if (w_scan_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_valid = 1'b1;
        // A new edge starts the next set at slot 0.
        if (w_edge) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_cnt_nxt   = (IDXW + 1)'(1);
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand buffer (not cleared by reset; contents are only read after a
  // complete set has been loaded)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_addr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt <= '0;
    end else if (w_wr_en) begin
      r_load_cnt <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Scan comparator
  // --------------------------------------------------------------------------
  assign w_cur = r_buf[r_p];

`ifdef SEQ_MIN_SIGNED_EN
  assign w_less = ($signed(w_cur) < $signed(r_run_val));
`else
  assign w_less = (w_cur < r_run_val);
`endif

  // Entry 0 seeds the running minimum; afterwards only a strictly smaller
  // value replaces it, so ties keep the lower index.
  assign w_take = (r_p == '0) || w_less;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '0;
      r_run_val <= '0;
      r_run_idx <= '0;
      r_min_val <= '0;
      r_min_idx <= '0;
    end else if (r_state == SCAN) begin
      if (w_take) begin
        r_run_val <= w_cur;
        r_run_idx <= r_p;
      end
      if (w_scan_last) begin
        // Publish the final result; outputs stay stable during the scan.
        r_p       <= '0;
        r_min_val <= w_take ? w_cur : r_run_val;
        r_min_idx <= w_take ? r_p   : r_run_idx;
      end else begin
        r_p <= r_p + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.min_val  = r_min_val;
  assign bus.min_idx  = r_min_idx;
  assign bus.valid    = w_valid;
  assign bus.busy     = w_busy;
  assign bus.load_cnt = r_load_cnt;

endmodule : seq_min_finder
`default_nettype wire

// File: tb/tb_seq_min_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_min_finder
//  Purpose  : Directed self-checking bench for seq_min_finder (W=3, N=4).
//             Expected results follow SEQ_MIN_SIGNED_EN when it is defined.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_min_finder;
  import seq_min_pkg::*;

  localparam int W = 3;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_min_finder_if #(.W(W), .N(N)) bus ();

  seq_min_finder #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Low for 3 cycles, then high for 3 cycles; returns just after the write
  // edge (two cycles of synchroniser latency plus the write itself).
  task automatic load_op(input logic [2:0] d, input int exp_cnt, input string tag);
    bus.in_strobe = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_data   = d;
    bus.in_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_strobe = 1'b0;
    chk(tag, 32'(bus.load_cnt), 32'(exp_cnt));
  endtask

  // Called right after the Nth write: busy must last exactly N cycles,
  // then valid with the expected result.
  task automatic wait_result(input string tag, input int exp_val, input int exp_idx);
    int cnt = 0;
    while (bus.busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(N));
    chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
    chk({tag, "_min_val"}, 32'(bus.min_val), 32'(exp_val));
    chk({tag, "_min_idx"}, 32'(bus.min_idx), 32'(exp_idx));
  endtask

  logic       bz [10];
  logic       vd [10];
  logic [2:0] lc [10];
  logic [9:0] pat;

  initial begin
    int e_mix_val, e_mix_idx, e_desc_val, e_desc_idx;
`ifdef SEQ_MIN_SIGNED_EN
    e_mix_val  = 4; e_mix_idx  = 2;   // 3, -1, -4, 0
    e_desc_val = 4; e_desc_idx = 2;   // -2, -3, -4, 3
`else
    e_mix_val  = 0; e_mix_idx  = 3;
    e_desc_val = 3; e_desc_idx = 3;
`endif

    // ---------------- reset state ----------------
    rst           = 1'b1;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    repeat (3) @(negedge clk);
    chk("rst_load_cnt", 32'(bus.load_cnt), 32'd0);
    chk("rst_valid",    32'(bus.valid),    32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_min_val",  32'(bus.min_val),  32'd0);
    chk("rst_min_idx",  32'(bus.min_idx),  32'd0);
    rst = 1'b0;

    // ---------------- 5,2,7,2 with edges during SCAN ----------------
    load_op(3'd5, 1, "t1_cnt1");
    load_op(3'd2, 2, "t1_cnt2");
    load_op(3'd7, 3, "t1_cnt3");
    repeat (3) @(negedge clk);
    // Strobe toggles every cycle: one real load, then two edges that land
    // during SCAN (the last on the completing cycle) and must be dropped.
    pat = 10'b0000010101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bz[i] = bus.busy;
      vd[i] = bus.valid;
      lc[i] = bus.load_cnt;
      bus.in_data   = (i <= 2) ? 3'd2 : 3'd0;
      bus.in_strobe = pat[i];
    end
    chk("t1_busy_before", 32'(bz[2]), 32'd0);
    chk("t1_cnt_before",  32'(lc[2]), 32'd3);
    chk("t1_busy_first",  32'(bz[3]), 32'd1);
    chk("t1_cnt4",        32'(lc[3]), 32'd4);
    chk("t1_busy_last",   32'(bz[6]), 32'd1);
    chk("t1_valid_early", 32'(vd[6]), 32'd0);
    chk("t1_busy_end",    32'(bz[7]), 32'd0);
    chk("t1_valid_n1",    32'(vd[7]), 32'd1);
    chk("t1_valid_hold",  32'(vd[9]), 32'd1);
    chk("t1_cnt_hold",    32'(lc[9]), 32'd4);
    chk("t1_min_val",     32'(bus.min_val), 32'd2);
    chk("t1_min_idx",     32'(bus.min_idx), 32'd1);

    // ---------------- restart after DONE: 6,6,6,6 ----------------
    load_op(3'd6, 1, "t2_cnt1");
    chk("t2_valid_drop", 32'(bus.valid), 32'd0);
    chk("t2_min_hold",   32'(bus.min_val), 32'd2);
    load_op(3'd6, 2, "t2_cnt2");
    load_op(3'd6, 3, "t2_cnt3");
    load_op(3'd6, 4, "t2_cnt4");
    wait_result("t2", 6, 0);

    // ---------------- signed/unsigned: 3,7,4,0 ----------------
    load_op(3'd3, 1, "t3_cnt1");
    load_op(3'd7, 2, "t3_cnt2");
    load_op(3'd4, 3, "t3_cnt3");
    load_op(3'd0, 4, "t3_cnt4");
    wait_result("t3", e_mix_val, e_mix_idx);

    // ---------------- descending: 6,5,4,3 ----------------
    load_op(3'd6, 1, "t4_cnt1");
    load_op(3'd5, 2, "t4_cnt2");
    load_op(3'd4, 3, "t4_cnt3");
    load_op(3'd3, 4, "t4_cnt4");
    wait_result("t4", e_desc_val, e_desc_idx);

    // ---------------- reset after 2 loads ----------------
    load_op(3'd1, 1, "t5_cnt1");
    load_op(3'd1, 2, "t5_cnt2");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_cnt",     32'(bus.load_cnt), 32'd0);
    chk("t5_rst_valid",   32'(bus.valid),    32'd0);
    chk("t5_rst_busy",    32'(bus.busy),     32'd0);
    chk("t5_rst_min_val", 32'(bus.min_val),  32'd0);
    chk("t5_rst_min_idx", 32'(bus.min_idx),  32'd0);
    rst = 1'b0;
    load_op(3'd2, 1, "t5_cnt1b");
    load_op(3'd3, 2, "t5_cnt2b");
    load_op(3'd1, 3, "t5_cnt3b");
    load_op(3'd3, 4, "t5_cnt4b");
    wait_result("t5", 1, 2);

    // ---------------- reset during SCAN ----------------
    load_op(3'd4, 1, "t6_cnt1");
    load_op(3'd5, 2, "t6_cnt2");
    load_op(3'd6, 3, "t6_cnt3");
    load_op(3'd7, 4, "t6_cnt4");
    chk("t6_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy",  32'(bus.busy),     32'd0);
    chk("t6_rst_cnt",   32'(bus.load_cnt), 32'd0);
    chk("t6_rst_valid", 32'(bus.valid),    32'd0);

    // ---------------- strobe held high through reset ----------------
    bus.in_strobe = 1'b1;
    bus.in_data   = 3'd5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_no_edge_cnt", 32'(bus.load_cnt), 32'd0);
    load_op(3'd5, 1, "t7_cnt1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_min_finder
`default_nettype wire
